// File: rtl/gpr_byp_ctl_if.sv
// rtl/gpr_byp_ctl_if.sv - issue/bypass bundle between issue stage and gpr_byp_ctl
interface gpr_byp_ctl_if #(
    parameter int TAG_W = 5
);
    logic             adv;
    logic             flush;
    logic             iss_vld;
    logic             iss_wr;
    logic [TAG_W-1:0] iss_tag;
    logic             iss_ld;
    logic             rd_a_en;
    logic             rd_b_en;
    logic [TAG_W-1:0] rd_a_tag;
    logic [TAG_W-1:0] rd_b_tag;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic             stall;
    logic             iss_take;

    modport master (
        output adv, flush, iss_vld, iss_wr, iss_tag, iss_ld,
               rd_a_en, rd_b_en, rd_a_tag, rd_b_tag,
        input  sel_a, sel_b, stall, iss_take
    );

    modport slave (
        input  adv, flush, iss_vld, iss_wr, iss_tag, iss_ld,
               rd_a_en, rd_b_en, rd_a_tag, rd_b_tag,
        output sel_a, sel_b, stall, iss_take
    );
endinterface

// File: rtl/gpr_byp_ctl.sv
// rtl/gpr_byp_ctl.sv - GPR operand bypass select and RAW stall control
// Optional MEM-stage bypass enabled by defining GPR_BYP_MEM_EN.
module gpr_byp_ctl #(
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    gpr_byp_ctl_if.slave bus
);

    logic             ex_v, ex_wr, ex_ld;
    logic             mem_v, mem_wr, mem_ld;
    logic             wb_v, wb_wr, wb_ld;
    logic [TAG_W-1:0] ex_tag, mem_tag, wb_tag;

    logic [4:0] res_a, res_b;

    // Result is {hazard, one-hot select}; youngest producer wins.
    function automatic logic [4:0] resolve(input logic en, input logic [TAG_W-1:0] tag);
        logic m_ex, m_mem, m_wb;
        m_ex    = en && ex_v  && ex_wr  && (ex_tag  == tag);
        m_mem   = en && mem_v && mem_wr && (mem_tag == tag);
        m_wb    = en && wb_v  && wb_wr  && (wb_tag  == tag);
        resolve = 5'b0_0001;
        if (m_ex) begin
            resolve = ex_ld ? 5'b1_0001 : 5'b0_0010;
        end else if (m_mem) begin
`ifdef GPR_BYP_MEM_EN
            resolve = mem_ld ? 5'b1_0001 : 5'b0_0100;
`else
            resolve = 5'b1_0001;
`endif
        end else if (m_wb) begin
            resolve = 5'b0_1000;
        end
    endfunction

    always_comb begin
        res_a        = resolve(bus.rd_a_en, bus.rd_a_tag);
        res_b        = resolve(bus.rd_b_en, bus.rd_b_tag);
        bus.sel_a    = res_a[3:0];
        bus.sel_b    = res_b[3:0];
        bus.stall    = bus.iss_vld && (res_a[4] || res_b[4]);
        bus.iss_take = bus.iss_vld && bus.adv && !bus.stall && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v    <= 1'b0;
            ex_wr   <= 1'b0;
            ex_ld   <= 1'b0;
            ex_tag  <= '0;
            mem_v   <= 1'b0;
            mem_wr  <= 1'b0;
            mem_ld  <= 1'b0;
            mem_tag <= '0;
            wb_v    <= 1'b0;
            wb_wr   <= 1'b0;
            wb_ld   <= 1'b0;
            wb_tag  <= '0;
        end else begin
            if (bus.adv) begin
                wb_v   <= mem_v;
                wb_wr  <= mem_wr;
                wb_ld  <= mem_ld;
                wb_tag <= mem_tag;
            end
            // Flush kills EX/MEM even when the pipe is held; MEM still drains to WB above.
            if (bus.flush) begin
                ex_v  <= 1'b0;
                mem_v <= 1'b0;
            end else if (bus.adv) begin
                ex_v    <= bus.iss_take;
                ex_wr   <= bus.iss_wr;
                ex_ld   <= bus.iss_ld;
                ex_tag  <= bus.iss_tag;
                mem_v   <= ex_v;
                mem_wr  <= ex_wr;
                mem_ld  <= ex_ld;
                mem_tag <= ex_tag;
            end
        end
    end

endmodule

// File: tb/tb_gpr_byp_ctl.sv
// tb/tb_gpr_byp_ctl.sv - directed self-checking bench for gpr_byp_ctl
module tb_gpr_byp_ctl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    gpr_byp_ctl_if #(.TAG_W(5)) bus ();

    gpr_byp_ctl #(.TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic wr, input logic [4:0] tag, input logic ld,
                         input logic aen, input logic [4:0] atag,
                         input logic ben, input logic [4:0] btag);
        bus.iss_vld  = vld;
        bus.iss_wr   = wr;
        bus.iss_tag  = tag;
        bus.iss_ld   = ld;
        bus.rd_a_en  = aen;
        bus.rd_a_tag = atag;
        bus.rd_b_en  = ben;
        bus.rd_b_tag = btag;
    endtask

    // Drive just after a rising edge, leave the caller at the following falling edge.
    task automatic step(input logic vld, input logic wr, input logic [4:0] tag, input logic ld,
                        input logic aen, input logic [4:0] atag,
                        input logic ben, input logic [4:0] btag);
        @(posedge clk);
        #1;
        drive(vld, wr, tag, ld, aen, atag, ben, btag);
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.adv   = 1'b1;
        bus.flush = 1'b0;
        drive(1, 1, 5'd3, 0, 1, 5'd3, 0, 5'd0);
        @(negedge clk);
        chk("rst_sel_a", {4'b0, bus.sel_a}, 8'h01);
        chk("rst_sel_b", {4'b0, bus.sel_b}, 8'h01);
        chk("rst_stall", {7'b0, bus.stall}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ALU producer then direct consumer: EX bypass
        step(1, 1, 5'd3, 0, 0, 5'd0, 0, 5'd0);
        chk("alu_take", {7'b0, bus.iss_take}, 8'h01);
        step(1, 0, 5'd0, 0, 1, 5'd3, 0, 5'd0);
        chk("alu_sel_a", {4'b0, bus.sel_a}, 8'h02);
        chk("alu_stall", {7'b0, bus.stall}, 8'h00);

        // Load-use: two stalled advancing cycles, then WB bypass
        step(1, 1, 5'd7, 1, 0, 5'd0, 0, 5'd0);
        chk("ld_take", {7'b0, bus.iss_take}, 8'h01);
        step(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7);
        chk("lu_stall1", {7'b0, bus.stall}, 8'h01);
        chk("lu_sel_b1", {4'b0, bus.sel_b}, 8'h01);
        chk("lu_take1", {7'b0, bus.iss_take}, 8'h00);
        step(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7);
        chk("lu_stall2", {7'b0, bus.stall}, 8'h01);
        step(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7);
        chk("lu_stall3", {7'b0, bus.stall}, 8'h00);
        chk("lu_sel_b3", {4'b0, bus.sel_b}, 8'h08);
        chk("lu_take3", {7'b0, bus.iss_take}, 8'h01);

        // r5 in EX, MEM and WB: EX wins, and holding the pipe changes nothing
        step(1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0);
        step(1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0);
        step(1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 1, 5'd5, 0, 5'd0);
        chk("prio_sel_a", {4'b0, bus.sel_a}, 8'h02);
        chk("prio_stall", {7'b0, bus.stall}, 8'h00);
        #1;
        bus.adv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_sel_a", {4'b0, bus.sel_a}, 8'h02);
            chk("hold_take", {7'b0, bus.iss_take}, 8'h00);
        end
        @(posedge clk);
        #1;
        bus.adv = 1'b1;

        // Both operands: r2 (ALU) in MEM, r9 in WB
        step(1, 1, 5'd9, 0, 0, 5'd0, 0, 5'd0);
        step(1, 1, 5'd2, 0, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 1, 5'd2, 1, 5'd9);
        chk("both_sel_b", {4'b0, bus.sel_b}, 8'h08);
`ifdef GPR_BYP_MEM_EN
        chk("both_sel_a", {4'b0, bus.sel_a}, 8'h04);
        chk("both_stall", {7'b0, bus.stall}, 8'h00);
`else
        chk("both_stall", {7'b0, bus.stall}, 8'h01);
        chk("both_take", {7'b0, bus.iss_take}, 8'h00);
        step(1, 0, 5'd0, 0, 1, 5'd2, 1, 5'd9);
        chk("both_wb_sel_a", {4'b0, bus.sel_a}, 8'h08);
        chk("both_wb_sel_b", {4'b0, bus.sel_b}, 8'h01);
        chk("both_wb_stall", {7'b0, bus.stall}, 8'h00);
`endif

        // Flush while stalled on a load in EX
        step(1, 1, 5'd4, 1, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 1, 5'd4, 0, 5'd0);
        chk("fl_stall", {7'b0, bus.stall}, 8'h01);
        bus.flush = 1'b1;
        #1;
        chk("fl_take", {7'b0, bus.iss_take}, 8'h00);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fl_post_stall", {7'b0, bus.stall}, 8'h00);
        chk("fl_post_sel_a", {4'b0, bus.sel_a}, 8'h01);

        // Disabled read against an EX load
        step(1, 1, 5'd6, 1, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 0, 5'd6, 0, 5'd0);
        chk("dis_sel_a", {4'b0, bus.sel_a}, 8'h01);
        chk("dis_stall", {7'b0, bus.stall}, 8'h00);
        chk("dis_take", {7'b0, bus.iss_take}, 8'h01);

        // Tag 0 is an ordinary register
        step(1, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd0);
        chk("r0_sel_b", {4'b0, bus.sel_b}, 8'h02);

        // Asynchronous reset mid-operation clears the in-flight producer
        step(1, 1, 5'd8, 0, 0, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 0, 1, 5'd8, 0, 5'd0);
        chk("mid_pre_sel_a", {4'b0, bus.sel_a}, 8'h02);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel_a", {4'b0, bus.sel_a}, 8'h01);
        chk("mid_rst_stall", {7'b0, bus.stall}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("idle_take", {7'b0, bus.iss_take}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
